fifo_512x128_reader: RTL

FIFO_512X128_READER -- requirements
Module: fifo_512x128_reader

---
 rtl/fifo_reader_pkg.sv | 28 ++
 rtl/fifo_512x128_reader_if.sv | 36 +++
 rtl/skid_buf_128.sv | 58 +++++
 rtl/fifo_512x128_reader.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the 512x128 FIFO reader: widths, FSM states and
// the per-byte even-parity check applied to every popped word.
package fifo_reader_pkg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned PAR_W  = DATA_W / 8;
    localparam int unsigned SKID_W = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Returns 1 when any byte's XOR disagrees with its parity bit.
    function automatic logic parity_bad(input logic [DATA_W-1:0] data,
                                        input logic [PAR_W-1:0]  par);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < PAR_W; i++) begin
            if ((^data[8*i +: 8]) != par[i]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/fifo_512x128_reader_if.sv
// FIFO-side and output-stream signals of the reader, grouped as one bundle.
interface fifo_512x128_reader_if;
    import fifo_reader_pkg::*;

    logic [DATA_W-1:0] fifo_dout;
    logic [PAR_W-1:0]  fifo_doutp;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              s_out_valid;
    logic              s_out_rdy;
    logic [DATA_W-1:0] s_out_data;
    logic              s_out_last;

    modport master (
        input  fifo_dout,
        input  fifo_doutp,
        input  fifo_empty,
        output fifo_rd_en,
        output s_out_valid,
        input  s_out_rdy,
        output s_out_data,
        output s_out_last
    );

    modport slave (
        output fifo_dout,
        output fifo_doutp,
        output fifo_empty,
        input  fifo_rd_en,
        input  s_out_valid,
        output s_out_rdy,
        input  s_out_data,
        input  s_out_last
    );

endinterface

// File: rtl/skid_buf_128.sv
// Two-entry skid buffer carrying a data word plus its last flag; entry 0 is
// always the head presented downstream.
module skid_buf_128
    import fifo_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [SKID_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [SKID_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [SKID_W-1:0] mem0;
    logic [SKID_W-1:0] mem1;
    logic [1:0]        cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0 <= '0;
            mem1 <= '0;
            cnt  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        mem0 <= push_data;
                    end else begin
                        mem1 <= push_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (cnt == 2'd2) begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end else begin
                        mem0 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = (cnt != 2'd0);
    assign out_data  = mem0;
    assign count     = cnt;

endmodule

// File: rtl/fifo_512x128_reader.sv
// Reads a frame of len words from an FWFT 512x128 FIFO, checks byte parity
// and forwards the words through a 2-entry skid buffer with a last marker.
module fifo_512x128_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fifo_512x128_reader_if.master      bus,
    input  logic                       start,
    input  logic [CNT_W-1:0]           len,
    output logic                       busy,
    output logic                       done,
    output logic                       par_err,
    output logic [CNT_W-1:0]           par_err_cnt
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   popped;
    logic               push;
    logic               accept;
    logic               room;
    logic               last_in;
    logic               skid_valid;
    logic [SKID_W-1:0]  skid_head;
    logic [1:0]         skid_count;

    assign accept  = skid_valid && bus.s_out_rdy;
    // A full buffer still has room when its head leaves on this same edge.
    assign room    = (skid_count != 2'd2) || accept;
    assign last_in = (popped == len_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                push = !bus.fifo_empty && (popped < len_q) && room;
                if (push && last_in) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept && skid_head[DATA_W]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            popped      <= '0;
            done        <= 1'b0;
            par_err     <= 1'b0;
            par_err_cnt <= '0;
        end else begin
            done <= 1'b0;
            if ((state == ST_IDLE) && start) begin
                len_q       <= len;
                popped      <= '0;
                par_err     <= 1'b0;
                par_err_cnt <= '0;
                if (len == '0) begin
                    done <= 1'b1;
                end
            end
            if (push) begin
                popped <= popped + CNT_W'(1);
                if ((PARITY_EN != 0) && parity_bad(bus.fifo_dout, bus.fifo_doutp)) begin
                    par_err <= 1'b1;
                    if (par_err_cnt != '1) begin
                        par_err_cnt <= par_err_cnt + CNT_W'(1);
                    end
                end
            end
            if ((state == ST_DRAIN) && accept && skid_head[DATA_W]) begin
                done <= 1'b1;
            end
        end
    end

    skid_buf_128 u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({last_in, bus.fifo_dout}),
        .pop       (accept),
        .out_valid (skid_valid),
        .out_data  (skid_head),
        .count     (skid_count)
    );

    assign bus.fifo_rd_en  = push;
    assign bus.s_out_valid = skid_valid;
    assign bus.s_out_data  = skid_head[DATA_W-1:0];
    assign bus.s_out_last  = skid_valid && skid_head[DATA_W];
    assign busy            = (state != ST_IDLE);

endmodule
